// File: rtl/ucode_seq.sv
// Microcode sequencer: decodes the current microword into next-micro-PC control.
// Optional return stack enabled with macro UCODE_CALL_STACK_EN.
module ucode_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  upc,
  input  logic [15:0] uword,
  input  logic [2:0]  cond_in,
  input  logic        start,
  output logic        load_incr,
  output logic [4:0]  upc_next,
  output logic [5:0]  ctrl,
  output logic        halted,
  output logic        ovf,
  output logic        unf
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 6;

  typedef enum logic [2:0] {
    OP_NEXT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_BCOND = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_LDCNT = 3'd5,
    OP_DJNZ  = 3'd6,
    OP_HALT  = 3'd7
  } op_e;

  op_e           op;
  logic [1:0]    csel;
  logic [AW-1:0] tgt;
  logic [CW-1:0] ctl;
  logic          cond_ok;
  logic [AW-1:0] cnt_q, cnt_d;

`ifdef UCODE_CALL_STACK_EN
  logic [1:0][AW-1:0] stk_q, stk_d;
  logic [1:0]         depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [AW-1:0]      ret_addr;
`endif

  // Field extraction and branch condition select
  always_comb begin
    op      = op_e'(uword[15:13]);
    csel    = uword[12:11];
    tgt     = uword[10:6];
    ctl     = uword[5:0];
    cond_ok = (csel == 2'd0) ? 1'b1 : cond_in[csel - 2'd1];
  end

  assign ctrl = reset ? '0 : ctl;

  // Next-PC decode and state next-values
  always_comb begin
    load_incr = 1'b0;
    upc_next  = '0;
    halted    = 1'b0;
    cnt_d     = cnt_q;
`ifdef UCODE_CALL_STACK_EN
    stk_d     = stk_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ret_addr  = upc + AW'(1);
`endif
    case (op)
      OP_NEXT: ;
      OP_JMP: begin
        load_incr = 1'b1;
        upc_next  = tgt;
      end
      OP_BCOND: begin
        load_incr = cond_ok;
        upc_next  = tgt;
      end
      OP_CALL: begin
        load_incr = 1'b1;
        upc_next  = tgt;
`ifdef UCODE_CALL_STACK_EN
        if (depth_q == 2'd2) begin
          ovf_d = 1'b1;
        end else begin
          stk_d[depth_q[0]] = ret_addr;
          depth_d           = depth_q + 2'd1;
        end
`endif
      end
      OP_RET: begin
`ifdef UCODE_CALL_STACK_EN
        load_incr = 1'b1;
        if (depth_q == 2'd0) begin
          unf_d = 1'b1;
        end else begin
          // depth 1 -> entry 0, depth 2 -> entry 1
          upc_next = stk_q[depth_q[1]];
          depth_d  = depth_q - 2'd1;
        end
`endif
      end
      OP_LDCNT: cnt_d = tgt;
      OP_DJNZ: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - AW'(1);
          load_incr = (cnt_q != AW'(1));
          upc_next  = tgt;
        end
      end
      OP_HALT: begin
        halted    = 1'b1;
        load_incr = 1'b1;
        upc_next  = start ? '0 : upc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef UCODE_CALL_STACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      stk_q   <= stk_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_ucode_seq.sv
// Self-checking bench for ucode_seq: constant vector table, directed corner
// sequences and randomized microwords checked against a queue-based model.
module tb_ucode_seq;

`ifdef UCODE_CALL_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  upc;
  logic [15:0] uword;
  logic [2:0]  cond_in;
  logic        start;
  logic        load_incr;
  logic [4:0]  upc_next;
  logic [5:0]  ctrl;
  logic        halted;
  logic        ovf;
  logic        unf;

  ucode_seq dut (
    .clk       (clk),
    .reset     (reset),
    .upc       (upc),
    .uword     (uword),
    .cond_in   (cond_in),
    .start     (start),
    .load_incr (load_incr),
    .upc_next  (upc_next),
    .ctrl      (ctrl),
    .halted    (halted),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_cnt;
  int m_stk[$];
  bit m_ovf, m_unf;
  bit e_ld, e_halt;
  int e_nx;

  typedef struct {
    logic [4:0]  upc;
    logic [15:0] w;
    logic [2:0]  c;
    logic        s;
    logic        ld;
    logic [4:0]  nx;
    logic        h;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [15:0] mk(int op, int cs, int tg, int ct);
    return {3'(op), 2'(cs), 5'(tg), 6'(ct)};
  endfunction

  function automatic vec_t mkv(int u, logic [15:0] w, int c, int s, int ld, int nx, int h);
    vec_t v;
    v.upc = 5'(u); v.w = w; v.c = 3'(c); v.s = 1'(s);
    v.ld = 1'(ld); v.nx = 5'(nx); v.h = 1'(h);
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Evaluate current inputs; commit=1 applies the clock-edge state change
  task automatic model(input bit commit);
    int op, csel, tgt;
    bit c;
    op   = int'(uword[15:13]);
    csel = int'(uword[12:11]);
    tgt  = int'(uword[10:6]);
    c    = (csel == 0) ? 1'b1 : cond_in[csel-1];
    e_ld = 0; e_nx = 0; e_halt = 0;
    case (op)
      1: begin e_ld = 1; e_nx = tgt; end
      2: begin e_ld = c; e_nx = tgt; end
      3: begin
        e_ld = 1; e_nx = tgt;
        if (STK_EN && commit) begin
          if (m_stk.size() < 2) m_stk.push_back((int'(upc) + 1) % 32);
          else m_ovf = 1;
        end
      end
      4: if (STK_EN) begin
        e_ld = 1;
        if (m_stk.size() > 0) begin
          e_nx = m_stk[$];
          if (commit) void'(m_stk.pop_back());
        end else begin
          e_nx = 0;
          if (commit) m_unf = 1;
        end
      end
      5: if (commit) m_cnt = tgt;
      6: if (m_cnt != 0) begin
        e_ld = (m_cnt != 1); e_nx = tgt;
        if (commit) m_cnt = m_cnt - 1;
      end
      7: begin e_halt = 1; e_ld = 1; e_nx = start ? 0 : int'(upc); end
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    model(1'b0);
    chk({tag, ".load_incr"}, int'(load_incr), int'(e_ld));
    if (e_ld) chk({tag, ".upc_next"}, int'(upc_next), e_nx);
    chk({tag, ".halted"}, int'(halted), int'(e_halt));
    chk({tag, ".ctrl"}, int'(ctrl), int'(uword[5:0]));
    chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
    chk({tag, ".unf"}, int'(unf), int'(m_unf));
  endtask

  task automatic step(input string tag, input int u, input logic [15:0] w, input int c, input int s);
    @(negedge clk);
    upc = 5'(u); uword = w; cond_in = 3'(c); start = 1'(s);
    #1;
    check_model(tag);
    @(posedge clk);
    model(1'b1);
  endtask

  // Reset asserted between clock edges; state must clear before any edge
  task automatic mid_reset(input string tag);
    @(negedge clk);
    uword = mk(0, 0, 0, 6'h3F);
    reset = 1'b1;
    #1;
    chk({tag, ".ctrl_rst"}, int'(ctrl), 0);
    chk({tag, ".ovf_rst"}, int'(ovf), 0);
    chk({tag, ".unf_rst"}, int'(unf), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; upc = '0; uword = mk(0, 0, 0, 6'h15); cond_in = '0; start = 1'b0;
    model_reset();

    tbl[0]  = mkv(31, mk(0, 0, 0, 6'h2A), 7, 1, 0, 0, 0);
    tbl[1]  = mkv(3,  mk(1, 0, 17, 6'h15), 0, 0, 1, 17, 0);
    tbl[2]  = mkv(4,  mk(2, 2, 9, 6'h01), 3'b010, 0, 1, 9, 0);
    tbl[3]  = mkv(4,  mk(2, 2, 9, 6'h02), 3'b000, 0, 0, 0, 0);
    tbl[4]  = mkv(6,  mk(2, 0, 3, 6'h04), 0, 0, 1, 3, 0);
    tbl[5]  = mkv(7,  mk(2, 3, 20, 6'h08), 3'b100, 0, 1, 20, 0);
    tbl[6]  = mkv(7,  mk(2, 1, 20, 6'h10), 3'b110, 0, 0, 0, 0);
    tbl[7]  = mkv(12, mk(7, 0, 5, 6'h20), 7, 0, 1, 12, 1);
    tbl[8]  = mkv(12, mk(7, 0, 5, 6'h21), 7, 0, 1, 12, 1);
    tbl[9]  = mkv(12, mk(7, 0, 5, 6'h22), 7, 0, 1, 12, 1);
    tbl[10] = mkv(12, mk(7, 0, 5, 6'h23), 0, 1, 1, 0, 1);
    tbl[11] = mkv(0,  mk(1, 0, 31, 6'h3F), 0, 0, 1, 31, 0);

    #1;
    chk("reset.ctrl", int'(ctrl), 0);
    chk("reset.ovf", int'(ovf), 0);
    chk("reset.unf", int'(unf), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      upc = tbl[i].upc; uword = tbl[i].w; cond_in = tbl[i].c; start = tbl[i].s;
      #1;
      chk($sformatf("tbl%0d.load_incr", i), int'(load_incr), int'(tbl[i].ld));
      if (tbl[i].ld) chk($sformatf("tbl%0d.upc_next", i), int'(upc_next), int'(tbl[i].nx));
      chk($sformatf("tbl%0d.halted", i), int'(halted), int'(tbl[i].h));
      chk($sformatf("tbl%0d.ctrl", i), int'(ctrl), int'(tbl[i].w[5:0]));
      @(posedge clk);
      model(1'b1);
    end

    // Loop counter: taken, taken, not taken, then fall through
    step("ldcnt3", 2, mk(5, 0, 3, 1), 0, 0);
    for (int i = 0; i < 4; i++) step($sformatf("djnz%0d", i), 3, mk(6, 0, 7, 2), 5, 1);

    // Return address wraps from 31 to 0
    mid_reset("r0");
    step("call31", 31, mk(3, 0, 4, 3), 0, 0);
    step("ret_wrap", 4, mk(4, 0, 0, 4), 0, 0);

    // Nested calls overflow, then returns underflow
    mid_reset("r1");
    step("call1", 1, mk(3, 0, 5, 5), 0, 0);
    step("call5", 5, mk(3, 0, 9, 6), 0, 0);
    step("call9", 9, mk(3, 0, 13, 7), 0, 0);
    step("ret_a", 13, mk(4, 0, 0, 8), 0, 0);
    step("ret_b", 6, mk(4, 0, 0, 9), 0, 0);
    step("ret_c", 2, mk(4, 0, 0, 10), 0, 0);
    step("after_unf", 0, mk(0, 0, 0, 11), 0, 0);

    // Reset mid-loop and mid-subroutine discards everything
    mid_reset("r2");
    step("ldcnt5", 3, mk(5, 0, 5, 12), 0, 0);
    step("call_a", 4, mk(3, 0, 20, 13), 0, 0);
    step("call_b", 20, mk(3, 0, 22, 14), 0, 0);
    step("call_c", 22, mk(3, 0, 24, 15), 0, 0);
    mid_reset("r3");
    step("ret_post", 24, mk(4, 0, 0, 16), 0, 0);
    step("djnz_post", 1, mk(6, 0, 9, 17), 0, 0);
    step("chk_post", 2, mk(0, 0, 0, 18), 0, 0);

    // Randomized microwords against the model
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset("rnd_rst");
      step("rnd", int'($urandom_range(0, 31)), 16'($urandom), int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
